// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg -- shared RISC-V definitions for the writeback stage and the
// load/store unit.
//
// Contents:
//   OP_*        major opcode constants (ir[6:0])
//   F3_*        load funct3 encodings (ir[14:12])
//   wb_state_t  writeback FSM state encoding
//   op_writes_rd()  true for opcodes that can write the register file
// ---------------------------------------------------------------------------
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_t;

    // Stores, branches and fences never produce a register result.
    function automatic logic op_writes_rd(input logic [6:0] op);
        return !((op == OP_STORE) || (op == OP_BRANCH) || (op == OP_FENCE));
    endfunction

endpackage

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align -- extracts a byte/halfword/word from an aligned memory word
// and sign- or zero-extends it to XLEN. Purely combinational.
//
// Parameters:
//   XLEN   datapath width, 32 or 64
//   OFF_W  byte-offset width, $clog2(XLEN/8)
// Ports:
//   funct3_i  in  3      load funct3 (LB/LH/LW/LD/LBU/LHU/LWU)
//   offset_i  in  OFF_W  low bits of the effective address
//   raw_i     in  XLEN   raw aligned memory word
//   data_o    out XLEN   formatted load value
// ---------------------------------------------------------------------------
module load_align
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [2:0]       funct3_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [XLEN-1:0]  raw_i,
    output logic [XLEN-1:0]  data_o
);

    // Lane offsets: the low offset bits below the access size are ignored.
    // For XLEN=32 the word mask clears every offset bit, so a word access
    // always takes the whole word.
    localparam logic [OFF_W-1:0] HALF_MASK = ~OFF_W'(1);
    localparam logic [OFF_W-1:0] WORD_MASK = ~OFF_W'(3);

    logic [OFF_W-1:0] half_off;
    logic [OFF_W-1:0] word_off;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      word_v;

    assign half_off = offset_i & HALF_MASK;
    assign word_off = offset_i & WORD_MASK;

    assign byte_v = 8'(raw_i >> {offset_i, 3'b000});
    assign half_v = 16'(raw_i >> {half_off, 3'b000});
    assign word_v = 32'(raw_i >> {word_off, 3'b000});

    always_comb begin
        // NOTE: every path assigns data_o (default first), so no latch is inferred.
        data_o = raw_i;
        case (funct3_i)
            F3_LB:  data_o = XLEN'($signed(byte_v));
            F3_LBU: data_o = XLEN'(byte_v);
            F3_LH:  data_o = XLEN'($signed(half_v));
            F3_LHU: data_o = XLEN'(half_v);
            F3_LW:  data_o = XLEN'($signed(word_v));
            F3_LWU: if (XLEN == 64) data_o = XLEN'(word_v);
            F3_LD:  data_o = raw_i;
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit -- RISC-V writeback stage driving the register-file write
// port. Selects link address / LUI immediate / formatted load / ALU result,
// and stalls upstream (in_ready=0) while a load response is outstanding.
//
// Optional feature: define WB_RETIRE_CNT_EN to add a 64-bit retire counter
// output (retire_cnt) that counts every completed instruction.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid / in_ready  upstream handshake (in_ready=1 only in IDLE)
//   ir, pc, alu_a        instruction word, its pc, execute result
//   addr_lo              low bits of the load effective address
//   mem_valid, mem_rdata load response strobe and raw aligned word
//   wb_en/addr/data      registered register-file write port (wb_en pulses)
//   busy                 high while waiting for load data
//   retire_cnt           (WB_RETIRE_CNT_EN only) completed-instruction count
// ---------------------------------------------------------------------------
module writeback_unit
    import rv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int PC_STEP = 1,
    parameter int OFF_W   = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       ir,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   alu_a,
    input  logic [OFF_W-1:0]  addr_lo,
    input  logic              mem_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [XLEN-1:0]   wb_data,
    output logic              busy
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]       retire_cnt
`endif
);

    wb_state_t state_q, state_d;

    logic [31:0]       ir_q;
    logic [OFF_W-1:0]  addr_lo_q;
    logic              wb_en_q, wb_en_d;
    logic [REG_AW-1:0] wb_addr_q;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    logic              accept;
    logic              in_is_load;
    logic              complete;
    logic [31:0]       sel_ir;
    logic [OFF_W-1:0]  sel_off;
    logic [6:0]        sel_op;
    logic [4:0]        sel_rd;
    logic [XLEN-1:0]   load_data;

    assign accept     = in_valid && in_ready;
    assign in_is_load = (ir[6:0] == OP_LOAD);

    // While waiting, the instruction on the inputs is not ours: format and
    // address the write from the captured load instead.
    assign sel_ir  = (state_q == LOAD_WAIT) ? ir_q      : ir;
    assign sel_off = (state_q == LOAD_WAIT) ? addr_lo_q : addr_lo;
    assign sel_op  = sel_ir[6:0];
    assign sel_rd  = sel_ir[11:7];

    // A completion is a non-load accept, a load accepted together with its
    // data, or load data arriving in LOAD_WAIT.
    assign complete = (state_q == LOAD_WAIT) ? mem_valid
                                             : (accept && (!in_is_load || mem_valid));

    load_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_align (
        .funct3_i (sel_ir[14:12]),
        .offset_i (sel_off),
        .raw_i    (mem_rdata),
        .data_o   (load_data)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept && in_is_load && !mem_valid) state_d = LOAD_WAIT;
            LOAD_WAIT: if (mem_valid)                          state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q == LOAD_WAIT);
    end

    // ---------------- Write data select ----------------
    always_comb begin
        wb_en_d = complete && op_writes_rd(sel_op) && (sel_rd != 5'd0);
        case (sel_op)
            OP_JAL, OP_JALR: wb_data_d = pc + XLEN'(PC_STEP);
            OP_LUI:          wb_data_d = XLEN'($signed({sel_ir[31:12], 12'b0}));
            OP_LOAD:         wb_data_d = load_data;
            default:         wb_data_d = alu_a;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q      <= '0;
            addr_lo_q <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            if (state_q == IDLE && accept && in_is_load && !mem_valid) begin
                ir_q      <= ir;
                addr_lo_q <= addr_lo;
            end
            wb_en_q <= wb_en_d;
            // Address and data hold their last written values on suppressed cycles.
            if (wb_en_d) begin
                wb_addr_q <= REG_AW'(sel_rd);
                wb_data_q <= wb_data_d;
            end
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)           retire_cnt_q <= '0;
        else if (complete) retire_cnt_q <= retire_cnt_q + 64'd1;
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_writeback_unit -- self-checking bench for writeback_unit (XLEN=32).
// Directed vector table, hand-written load-wait / reset sequences, then
// randomized traffic against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] alu_a;
    logic [1:0]  addr_lo;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_unit #(
        .XLEN    (32),
        .REG_AW  (5),
        .PC_STEP (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ir        (ir),
        .pc        (pc),
        .alu_a     (alu_a),
        .addr_lo   (addr_lo),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .busy      (busy)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- Reference model (spec rules, plain arithmetic) ----------------
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] raw);
        logic [31:0] b, h;
        b = (raw >> (8 * off)) & 32'hFF;
        h = (raw >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            default: return raw;   // LW is the whole word at XLEN=32
        endcase
    endfunction

    function automatic logic [31:0] model_value(input logic [31:0] ir_v, input logic [31:0] pc_v,
                                                input logic [31:0] alu_v, input logic [1:0] off,
                                                input logic [31:0] raw);
        case (ir_v[6:0])
            7'b1101111, 7'b1100111: return pc_v + 32'd1;
            7'b0110111:             return ir_v & 32'hFFFF_F000;
            7'b0000011:             return model_load(ir_v[14:12], off, raw);
            default:                return alu_v;
        endcase
    endfunction

    function automatic bit model_writes(input logic [31:0] ir_v);
        return !(ir_v[6:0] inside {7'b0100011, 7'b1100011, 7'b0001111}) && (ir_v[11:7] != 5'd0);
    endfunction

    // ---------------- Directed vector table ----------------
    typedef struct {
        string       name;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [1:0]  off;
        logic [31:0] rdata;
        logic        exp_en;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[14];

    typedef struct {
        logic [31:0] ir;
        logic [1:0]  off;
    } pend_t;

    initial begin
        // name, ir, pc, alu, addr_lo, mem_rdata, exp_en, exp_addr, exp_data
        vecs[0]  = '{"addi_rd5",   32'h0000_0293, 32'h0,         32'h0000_0042, 2'd0, 32'h0,         1'b1, 5'd5,  32'h0000_0042};
        vecs[1]  = '{"jal_rd1",    32'h0000_00EF, 32'h0000_0100, 32'h1234_5678, 2'd0, 32'h0,         1'b1, 5'd1,  32'h0000_0101};
        vecs[2]  = '{"jal_rd0",    32'h0000_006F, 32'h0000_0200, 32'h0,         2'd0, 32'h0,         1'b0, 5'd1,  32'h0000_0101};
        vecs[3]  = '{"store",      32'h0000_02A3, 32'h0,         32'hAAAA_AAAA, 2'd0, 32'h0,         1'b0, 5'd1,  32'h0000_0101};
        vecs[4]  = '{"branch",     32'h0000_0263, 32'h0,         32'hBBBB_BBBB, 2'd0, 32'h0,         1'b0, 5'd1,  32'h0000_0101};
        vecs[5]  = '{"fence",      32'h0000_028F, 32'h0,         32'hCCCC_CCCC, 2'd0, 32'h0,         1'b0, 5'd1,  32'h0000_0101};
        vecs[6]  = '{"lb_off2",    32'h0000_0383, 32'h0,         32'h0,         2'd2, 32'h1280_FF34, 1'b1, 5'd7,  32'hFFFF_FF80};
        vecs[7]  = '{"lhu_off2",   32'h0000_5403, 32'h0,         32'h0,         2'd2, 32'h1280_FF34, 1'b1, 5'd8,  32'h0000_1280};
        vecs[8]  = '{"lui",        32'h8000_04B7, 32'h0,         32'h0,         2'd0, 32'h0,         1'b1, 5'd9,  32'h8000_0000};
        vecs[9]  = '{"jalr_wrap",  32'h0000_0567, 32'hFFFF_FFFF, 32'h0,         2'd0, 32'h0,         1'b1, 5'd10, 32'h0000_0000};
        vecs[10] = '{"lh_off3",    32'h0000_1583, 32'h0,         32'h0,         2'd3, 32'h8001_0000, 1'b1, 5'd11, 32'hFFFF_8001};
        vecs[11] = '{"lbu_off3",   32'h0000_4603, 32'h0,         32'h0,         2'd3, 32'hAB00_0000, 1'b1, 5'd12, 32'h0000_00AB};
        vecs[12] = '{"lw_off1",    32'h0000_2683, 32'h0,         32'h0,         2'd1, 32'h1234_5678, 1'b1, 5'd13, 32'h1234_5678};
        vecs[13] = '{"load_f3_7",  32'h0000_7703, 32'h0,         32'h0,         2'd2, 32'hCAFE_F00D, 1'b1, 5'd14, 32'hCAFE_F00D};

        rst = 1'b1; in_valid = 1'b0; ir = '0; pc = '0; alu_a = '0;
        addr_lo = '0; mem_valid = 1'b0; mem_rdata = '0;

        // ---- 1. reset held two cycles ----
        step(); step();
        rst = 1'b0;
        check("reset_wb_en",    wb_en,    0);
        check("reset_wb_addr",  wb_addr,  0);
        check("reset_wb_data",  wb_data,  0);
        check("reset_in_ready", in_ready, 1);
        check("reset_busy",     busy,     0);
`ifdef WB_RETIRE_CNT_EN
        check("reset_retire", retire_cnt, 0);
`endif

        // ---- 2..7: table, back-to-back, mem_valid same cycle for loads ----
        foreach (vecs[i]) begin
            ir = vecs[i].ir; pc = vecs[i].pc; alu_a = vecs[i].alu;
            addr_lo = vecs[i].off; mem_rdata = vecs[i].rdata;
            in_valid = 1'b1; mem_valid = 1'b1;
            check({vecs[i].name, "_ready"}, in_ready, 1);
            step();
            check({vecs[i].name, "_en"},   wb_en,   vecs[i].exp_en);
            check({vecs[i].name, "_addr"}, wb_addr, vecs[i].exp_addr);
            check({vecs[i].name, "_data"}, wb_data, vecs[i].exp_data);
        end
        in_valid = 1'b0; mem_valid = 1'b0;
        step();
        check("pulse_end_en",   wb_en,   0);
        check("pulse_end_data", wb_data, 32'hCAFE_F00D);

        // ---- 8. LW waiting three cycles, in_valid during the wait ignored ----
        ir = 32'h0000_2783; addr_lo = 2'd0; in_valid = 1'b1; mem_valid = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            ir = 32'h0000_0A13; alu_a = 32'h55; in_valid = 1'b1;
            mem_valid = (i == 2); mem_rdata = 32'hDEAD_BEEF;
            check("lw_wait_ready", in_ready, 0);
            check("lw_wait_busy",  busy,     1);
            step();
            if (i < 2) check("lw_wait_en", wb_en, 0);
        end
        in_valid = 1'b0; mem_valid = 1'b0;
        check("lw_done_en",    wb_en,    1);
        check("lw_done_addr",  wb_addr,  15);
        check("lw_done_data",  wb_data,  32'hDEAD_BEEF);
        check("lw_done_ready", in_ready, 1);
        check("lw_done_busy",  busy,     0);
        step();
        check("lw_ignored_addi_en", wb_en, 0);

        // ---- captured offset/funct3, then back-to-back accept on the write cycle ----
        ir = 32'h0000_4803; addr_lo = 2'd1; in_valid = 1'b1; mem_valid = 1'b0;
        step();
        ir = 32'h0000_0883; addr_lo = 2'd0; mem_valid = 1'b1; mem_rdata = 32'h0000_C300;
        step();
        check("lbu_wait_en",   wb_en,   1);
        check("lbu_wait_addr", wb_addr, 16);
        check("lbu_wait_data", wb_data, 32'h0000_00C3);
        check("b2b_ready",     in_ready, 1);
        ir = 32'h0000_0913; alu_a = 32'h77; mem_valid = 1'b0;
        step();
        in_valid = 1'b0;
        check("b2b_en",   wb_en,   1);
        check("b2b_addr", wb_addr, 18);
        check("b2b_data", wb_data, 32'h77);

        // ---- 9. reset during LOAD_WAIT abandons the load ----
        ir = 32'h0000_2783; in_valid = 1'b1; mem_valid = 1'b0;
        step();
        check("pre_rst_busy", busy, 1);
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h1111_1111;
        step();
        mem_valid = 1'b0;
        check("rst_wait_en",    wb_en,    0);
        check("rst_wait_addr",  wb_addr,  0);
        check("rst_wait_data",  wb_data,  0);
        check("rst_wait_ready", in_ready, 1);
        check("rst_wait_busy",  busy,     0);

        // ---- randomized traffic against the queue model ----
        begin
            pend_t       pend[$];
            pend_t       p;
            logic [31:0] r;
            logic [6:0]  ops[10];
            logic        e_en;
            logic [4:0]  e_addr;
            logic [31:0] e_data;
            logic [63:0] e_ret;
            ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
                    7'b0110111, 7'b0001111, 7'b0010011, 7'b0110011, 7'b0000011};
            rst = 1'b1; in_valid = 1'b0; mem_valid = 1'b0;
            step();
            rst = 1'b0;
            e_en = 1'b0; e_addr = '0; e_data = '0; e_ret = '0;

            for (int cyc = 0; cyc < 400; cyc++) begin
                r         = $urandom();
                ir        = {r[31:7], ops[$urandom_range(9)]};
                if ($urandom_range(7) == 0) ir[11:7] = 5'd0;
                pc        = $urandom();
                alu_a     = $urandom();
                addr_lo   = 2'($urandom_range(3));
                mem_rdata = $urandom();
                in_valid  = ($urandom_range(99) < 70);
                mem_valid = ($urandom_range(99) < 40);
                rst       = ($urandom_range(99) == 0);

                check("rand_ready", in_ready, pend.size() == 0);

                e_en = 1'b0;
                if (rst) begin
                    pend.delete();
                    e_addr = '0; e_data = '0; e_ret = '0;
                end else if (pend.size() != 0) begin
                    if (mem_valid) begin
                        p = pend.pop_front();
                        e_ret++;
                        if (model_writes(p.ir)) begin
                            e_en = 1'b1; e_addr = p.ir[11:7];
                            e_data = model_load(p.ir[14:12], p.off, mem_rdata);
                        end
                    end
                end else if (in_valid) begin
                    if (ir[6:0] == 7'b0000011 && !mem_valid) begin
                        pend.push_back('{ir: ir, off: addr_lo});
                    end else begin
                        e_ret++;
                        if (model_writes(ir)) begin
                            e_en = 1'b1; e_addr = ir[11:7];
                            e_data = model_value(ir, pc, alu_a, addr_lo, mem_rdata);
                        end
                    end
                end

                step();
                check("rand_en",   wb_en,   e_en);
                check("rand_addr", wb_addr, e_addr);
                check("rand_data", wb_data, e_data);
                check("rand_busy", busy,    pend.size() != 0);
`ifdef WB_RETIRE_CNT_EN
                check("rand_retire", retire_cnt, e_ret);
`endif
            end
            rst = 1'b0; in_valid = 1'b0; mem_valid = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
